tic_tac_toe_auto_player: RTL and testbench
==========================================

// Module: tic_tac_toe_auto_player
// PURPOSE
//  Automatic O-side opponent for the tic-tac-toe game. Reads board cells pos1..pos9 and
//  produces the move stimulus the game consumes: a playO pulse with a 4-bit position code.
//  Sits beside the game top and drives its playO / playerO_position inputs; X stays human.
//  Strategy in fixed priority: win, block X, centre, corners, edges.
// PARAMETERS
//  THINK_CYCLES  4   idle cycles between o_turn seen and start of scan (>=1)
//  HOLD_CYCLES   2   cycles playO is held high per move (>=1)
//  ACK_TIMEOUT   16  cycles to wait for the move to land on the board before error
// PORTS
//  clk               in   1  system clock
//  rst               in   1  synchronous reset, active-high
//  enable            in   1  1 = auto player active; 0 = outputs idle
//  o_turn            in   1  game is waiting for an O move
//  pos1..pos9        in   2  board cells: 00 empty, 01 X, 10 O, 11 illegal (treated occupied)
//  playO             out  1  move strobe to game, high HOLD_CYCLES cycles
//  playerO_position  out  4  cell code 0..8 (0 = pos1 ... 8 = pos9); valid while playO=1
//  busy              out  1  1 in any state other than IDLE
//  no_move           out  1  1-cycle pulse: board full when scan ran, no move issued
//  ack_error         out  1  1-cycle pulse: chosen cell still empty after ACK_TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, snapshot cleared.
//  States: IDLE -> THINK -> SCAN_WIN -> SCAN_BLOCK -> SCAN_FALLBACK -> ISSUE -> WAIT_ACK -> IDLE.
//  IDLE: on enable & o_turn, snapshot pos1..pos9 into board register, go THINK.
//  THINK: count THINK_CYCLES, then SCAN_WIN with line index 0.
//  SCAN_WIN: one line per cycle, order {0,1,2},{3,4,5},{6,7,8},{0,3,6},{1,4,7},{2,5,8},
//    {0,4,8},{2,4,6}. Line with two O + one empty -> choose that empty cell, go ISSUE.
//    After line 7 with no hit -> SCAN_BLOCK.
//  SCAN_BLOCK: same order, two X + one empty -> choose, ISSUE; after line 7 -> SCAN_FALLBACK.
//  SCAN_FALLBACK: one cell per cycle, order 4,0,2,6,8,1,3,5,7; first empty -> ISSUE.
//    All nine occupied -> pulse no_move, IDLE.
//  First hit in scan order wins; win always beats block. Worst-case latency o_turn to playO:
//    1 + THINK_CYCLES + 8 + 8 + 9 cycles.
//  ISSUE: playO=1 and playerO_position=choice for exactly HOLD_CYCLES cycles; code stable
//    throughout; then WAIT_ACK. Position is 0 whenever playO=0.
//  WAIT_ACK: live cell at choice becomes 10 -> IDLE. Timeout counter reaches ACK_TIMEOUT
//    -> pulse ack_error, IDLE. Cell becoming 01 (X took it) also counts as ack_error.
//  Abort: enable=0 or o_turn=0 in THINK/SCAN_* -> IDLE next cycle, no strobe. Abort is
//    ignored during ISSUE (strobe completes) and WAIT_ACK (normal exit rules apply).
//  Re-arm: after returning to IDLE, a new move requires o_turn sampled high again; if o_turn
//    is still high the block restarts (game decides legality).
//  Scans use the snapshot only; live board changes mid-scan have no effect.
//  Code 11 in a cell: never chosen, never counted as O or X in a line.
//  rst mid-operation: playO drops the next edge, state IDLE, no pulses emitted.
// STRUCTURE
//  Package tic_tac_toe_pkg: cell_t enum (EMPTY=2'b00, MARK_X=2'b01, MARK_O=2'b10),
//    LINES[8][3] cell-index table, FALLBACK_ORDER[9], state_t enum.
//  Sub-module tic_tac_toe_line_eval (combinational): 3 cells + mark -> hit, empty index 0..2.
//    One instance shared by SCAN_WIN and SCAN_BLOCK (mark muxed by state).
//  Top holds FSM, snapshot register, line/cell/think/hold/timeout counters.
// TESTING
//  1 Empty board, o_turn=1, THINK=4 -> playO high 2 cycles, position 4; board echo 10 at pos5
//    -> busy falls, no ack_error.
//  2 O at 0,1, X at 3,4, rest empty -> position 2 (win beats block of 5).
//  3 X at 0,4, O at 1, rest empty -> position 8 (block diagonal).
//  4 Board full (no win) with o_turn=1 -> no_move pulse, playO never asserted.
//  5 o_turn dropped during SCAN_BLOCK -> IDLE next cycle, playO stays 0; rst asserted in ISSUE
//    -> playO=0 next cycle, all outputs 0.
//  6 Board never echoes the move -> ack_error pulse exactly ACK_TIMEOUT cycles after WAIT_ACK entry.

Source files
------------

// File: rtl/tic_tac_toe_pkg.sv
// Shared types and lookup tables for the automatic O-side tic-tac-toe player.
package tic_tac_toe_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b01,
        MARK_O = 2'b10
    } cell_t;

    typedef enum logic [2:0] {
        IDLE,
        THINK,
        SCAN_WIN,
        SCAN_BLOCK,
        SCAN_FALLBACK,
        ISSUE,
        WAIT_ACK
    } state_t;

    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned CNT_W     = 8;

    // Rows, columns, then diagonals; this order sets which hit wins a tie.
    localparam logic [3:0] LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Centre, corners, then edges.
    localparam logic [3:0] FALLBACK_ORDER [NUM_CELLS] = '{
        4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
    };

endpackage

// File: rtl/tic_tac_toe_line_eval.sv
// Combinational line check: two of `mark` plus exactly one empty cell is a hit.
module tic_tac_toe_line_eval
    import tic_tac_toe_pkg::*;
(
    input  logic [1:0] c0,
    input  logic [1:0] c1,
    input  logic [1:0] c2,
    input  logic [1:0] mark,
    output logic       hit_c,
    output logic [1:0] idx_c
);

    logic [1:0] n_mark;
    logic [1:0] n_empty;

    // Code 11 matches neither mark nor EMPTY, so it only ever blocks a line.
    always_comb begin
        n_mark  = 2'(c0 == mark) + 2'(c1 == mark) + 2'(c2 == mark);
        n_empty = 2'(c0 == EMPTY) + 2'(c1 == EMPTY) + 2'(c2 == EMPTY);
        hit_c   = (n_mark == 2'd2) && (n_empty == 2'd1);
        if (c0 == EMPTY)      idx_c = 2'd0;
        else if (c1 == EMPTY) idx_c = 2'd1;
        else                  idx_c = 2'd2;
    end

endmodule

// File: rtl/tic_tac_toe_auto_player.sv
// Automatic O-side opponent: snapshots the board, picks win/block/centre/corner/edge,
// strobes the move to the game and waits for it to land.
module tic_tac_toe_auto_player
    import tic_tac_toe_pkg::*;
#(
    parameter int unsigned THINK_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned ACK_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       o_turn,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    output logic       playO,
    output logic [3:0] playerO_position,
    output logic       busy,
    output logic       no_move,
    output logic       ack_error
);

    state_t            state, state_d;
    logic [8:0][1:0]   live;
    logic [8:0][1:0]   board, board_d;
    logic [CNT_W-1:0]  think_cnt, think_d;
    logic [CNT_W-1:0]  hold_cnt, hold_d;
    logic [CNT_W-1:0]  to_cnt, to_d;
    logic [2:0]        line_idx, line_d;
    logic [3:0]        cell_idx, cell_d;
    logic [3:0]        choice, choice_d;
    logic              play_d, busy_d, no_move_d, ack_error_d;
    logic [3:0]        pos_d;
    logic              abort;
    logic [1:0]        scan_mark;
    logic              line_hit;
    logic [1:0]        line_hit_idx;
    logic [3:0]        fb_cell;

    assign live      = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
    assign scan_mark = (state == SCAN_BLOCK) ? MARK_X : MARK_O;
    assign fb_cell   = FALLBACK_ORDER[cell_idx];

    tic_tac_toe_line_eval u_line_eval (
        .c0    (board[LINES[line_idx][0]]),
        .c1    (board[LINES[line_idx][1]]),
        .c2    (board[LINES[line_idx][2]]),
        .mark  (scan_mark),
        .hit_c (line_hit),
        .idx_c (line_hit_idx)
    );

    // Next-state, counter and output decode.
    always_comb begin
        state_d     = state;
        board_d     = board;
        think_d     = think_cnt;
        hold_d      = hold_cnt;
        to_d        = to_cnt;
        line_d      = line_idx;
        cell_d      = cell_idx;
        choice_d    = choice;
        no_move_d   = 1'b0;
        ack_error_d = 1'b0;
        abort       = !enable || !o_turn;

        case (state)
            IDLE: begin
                if (enable && o_turn) begin
                    board_d = live;
                    think_d = '0;
                    state_d = THINK;
                end
            end
            THINK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (think_cnt == CNT_W'(THINK_CYCLES - 1)) begin
                    line_d  = '0;
                    state_d = SCAN_WIN;
                end else begin
                    think_d = think_cnt + 1'b1;
                end
            end
            SCAN_WIN, SCAN_BLOCK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (line_hit) begin
                    choice_d = LINES[line_idx][line_hit_idx];
                    hold_d   = '0;
                    state_d  = ISSUE;
                end else if (line_idx == 3'd7) begin
                    line_d = '0;
                    cell_d = '0;
                    state_d = (state == SCAN_WIN) ? SCAN_BLOCK : SCAN_FALLBACK;
                end else begin
                    line_d = line_idx + 1'b1;
                end
            end
            SCAN_FALLBACK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (board[fb_cell] == EMPTY) begin
                    choice_d = fb_cell;
                    hold_d   = '0;
                    state_d  = ISSUE;
                end else if (cell_idx == 4'd8) begin
                    no_move_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cell_d = cell_idx + 1'b1;
                end
            end
            ISSUE: begin
                if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    to_d    = '0;
                    state_d = WAIT_ACK;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (live[choice] == MARK_O) begin
                    state_d = IDLE;
                end else if (live[choice] == MARK_X ||
                             to_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    ack_error_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_d = to_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        play_d = (state_d == ISSUE);
        pos_d  = play_d ? choice_d : 4'd0;
        busy_d = (state_d != IDLE);
    end

    // State, snapshot, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            board            <= '0;
            think_cnt        <= '0;
            hold_cnt         <= '0;
            to_cnt           <= '0;
            line_idx         <= '0;
            cell_idx         <= '0;
            choice           <= '0;
            playO            <= 1'b0;
            playerO_position <= '0;
            busy             <= 1'b0;
            no_move          <= 1'b0;
            ack_error        <= 1'b0;
        end else begin
            state            <= state_d;
            board            <= board_d;
            think_cnt        <= think_d;
            hold_cnt         <= hold_d;
            to_cnt           <= to_d;
            line_idx         <= line_d;
            cell_idx         <= cell_d;
            choice           <= choice_d;
            playO            <= play_d;
            playerO_position <= pos_d;
            busy             <= busy_d;
            no_move          <= no_move_d;
            ack_error        <= ack_error_d;
        end
    end

endmodule

// File: tb/tb_tic_tac_toe_auto_player.sv
// Directed self-checking bench for tic_tac_toe_auto_player (THINK=4, HOLD=2, ACK=16).
module tb_tic_tac_toe_auto_player;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            o_turn;
    logic [8:0][1:0] brd;
    logic            playO;
    logic [3:0]      playerO_position;
    logic            busy;
    logic            no_move;
    logic            ack_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tic_tac_toe_auto_player dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .o_turn           (o_turn),
        .pos1             (brd[0]),
        .pos2             (brd[1]),
        .pos3             (brd[2]),
        .pos4             (brd[3]),
        .pos5             (brd[4]),
        .pos6             (brd[5]),
        .pos7             (brd[6]),
        .pos8             (brd[7]),
        .pos9             (brd[8]),
        .playO            (playO),
        .playerO_position (playerO_position),
        .busy             (busy),
        .no_move          (no_move),
        .ack_error        (ack_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until playO is seen or the budget runs out; cyc = edges taken.
    task automatic wait_play(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget && playO !== 1'b1) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; o_turn = 1'b1; brd = '0;
        tick(); tick();
        checks++;
        if ({playO, playerO_position, busy, no_move, ack_error} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {playO, playerO_position, busy, no_move, ack_error});
        end
        enable = 1'b0; rst = 1'b0;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL disabled_idle busy=%b exp=0", busy);
        end
        o_turn = 1'b0; enable = 1'b1;
        tick();
    endtask

    task automatic test_empty_board();
        int cyc;
        int hold;
        logic stable;
        logic err_seen;
        brd = '0; o_turn = 1'b1;
        wait_play(40, cyc);
        checks++;
        if (playO !== 1'b1) begin failures++; $display("FAIL empty_timeout playO=%b exp=1", playO); end
        checks++;
        if (cyc !== 22) begin failures++; $display("FAIL empty_latency got=%0d exp=22", cyc); end
        checks++;
        if (playerO_position !== 4'd4) begin
            failures++; $display("FAIL empty_pos got=%0d exp=4", playerO_position);
        end
        o_turn = 1'b0;
        hold = 0; stable = 1'b1;
        while (playO === 1'b1 && hold < 10) begin
            if (playerO_position !== 4'd4) stable = 1'b0;
            tick();
            hold++;
        end
        checks++;
        if (hold !== 2) begin failures++; $display("FAIL hold_cycles got=%0d exp=2", hold); end
        checks++;
        if (stable !== 1'b1) begin failures++; $display("FAIL pos_stable got=%b exp=1", stable); end
        checks++;
        if (playerO_position !== 4'd0) begin
            failures++; $display("FAIL pos_idle got=%0d exp=0", playerO_position);
        end
        brd[4] = 2'b10;
        err_seen = ack_error;
        tick();
        err_seen |= ack_error;
        checks++;
        if ({busy, err_seen} !== 2'b00) begin
            failures++; $display("FAIL echo_exit busy,ack_error=%b exp=00", {busy, err_seen});
        end
    endtask

    task automatic test_win_beats_block();
        int cyc;
        logic err_seen;
        brd = '0;
        brd[0] = 2'b10; brd[1] = 2'b10; brd[3] = 2'b01; brd[4] = 2'b01;
        o_turn = 1'b1;
        wait_play(40, cyc);
        checks++;
        if (cyc !== 6 || playerO_position !== 4'd2) begin
            failures++; $display("FAIL win_pos got=%0d lat=%0d exp=2 lat=6", playerO_position, cyc);
        end
        o_turn = 1'b0;
        brd[2] = 2'b10;
        err_seen = 1'b0;
        repeat (6) begin tick(); err_seen |= ack_error; end
        checks++;
        if ({busy, err_seen} !== 2'b00) begin
            failures++; $display("FAIL win_exit busy,ack_error=%b exp=00", {busy, err_seen});
        end
    endtask

    task automatic test_block_and_x_steal();
        int cyc;
        brd = '0;
        brd[0] = 2'b01; brd[4] = 2'b01; brd[1] = 2'b10;
        o_turn = 1'b1;
        wait_play(40, cyc);
        checks++;
        if (cyc !== 20 || playerO_position !== 4'd8) begin
            failures++; $display("FAIL block_pos got=%0d lat=%0d exp=8 lat=20", playerO_position, cyc);
        end
        o_turn = 1'b0;
        cyc = 0;
        while (playO === 1'b1 && cyc < 10) begin tick(); cyc++; end
        brd[8] = 2'b01;
        tick();
        checks++;
        if (ack_error !== 1'b1) begin failures++; $display("FAIL x_steal ack_error=%b exp=1", ack_error); end
        tick();
        checks++;
        if ({ack_error, busy} !== 2'b00) begin
            failures++; $display("FAIL x_steal_pulse ack_error,busy=%b exp=00", {ack_error, busy});
        end
    endtask

    task automatic test_full_board();
        int cyc;
        logic play_seen;
        brd[0] = 2'b01; brd[1] = 2'b10; brd[2] = 2'b01;
        brd[3] = 2'b01; brd[4] = 2'b10; brd[5] = 2'b10;
        brd[6] = 2'b10; brd[7] = 2'b01; brd[8] = 2'b11;
        o_turn = 1'b1;
        cyc = 0; play_seen = 1'b0;
        while (no_move !== 1'b1 && cyc < 40) begin
            tick(); cyc++;
            play_seen |= playO;
        end
        o_turn = 1'b0;
        checks++;
        if (no_move !== 1'b1 || cyc !== 30) begin
            failures++; $display("FAIL no_move got=%b lat=%0d exp=1 lat=30", no_move, cyc);
        end
        checks++;
        if (play_seen !== 1'b0) begin failures++; $display("FAIL full_playO got=%b exp=0", play_seen); end
        tick();
        checks++;
        if ({no_move, busy} !== 2'b00) begin
            failures++; $display("FAIL no_move_pulse no_move,busy=%b exp=00", {no_move, busy});
        end
    endtask

    task automatic test_abort();
        int cyc;
        logic play_seen;
        brd = '0; o_turn = 1'b1;
        repeat (15) tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", busy); end
        o_turn = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle busy=%b exp=0", busy); end
        play_seen = 1'b0;
        repeat (30) begin tick(); play_seen |= playO; end
        checks++;
        if (play_seen !== 1'b0) begin failures++; $display("FAIL abort_playO got=%b exp=0", play_seen); end

        // Reset while strobing.
        o_turn = 1'b1;
        wait_play(40, cyc);
        checks++;
        if (playO !== 1'b1) begin failures++; $display("FAIL rst_issue_timeout playO=%b exp=1", playO); end
        rst = 1'b1;
        tick();
        checks++;
        if ({playO, playerO_position, busy, no_move, ack_error} !== 8'd0) begin
            failures++;
            $display("FAIL rst_in_issue got=%b exp=0", {playO, playerO_position, busy, no_move, ack_error});
        end
        o_turn = 1'b0;
        tick();
        rst = 1'b0;
        play_seen = 1'b0;
        repeat (5) begin tick(); play_seen |= playO | ack_error | no_move | busy; end
        checks++;
        if (play_seen !== 1'b0) begin failures++; $display("FAIL post_rst_quiet got=%b exp=0", play_seen); end
    endtask

    task automatic test_ack_timeout();
        int cyc;
        brd = '0;
        brd[0] = 2'b10; brd[1] = 2'b10; brd[3] = 2'b01; brd[4] = 2'b01;
        o_turn = 1'b1;
        wait_play(40, cyc);
        o_turn = 1'b0;
        cyc = 0;
        while (playO === 1'b1 && cyc < 10) begin tick(); cyc++; end
        cyc = 0;
        while (ack_error !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        checks++;
        if (cyc !== 16) begin failures++; $display("FAIL ack_timeout got=%0d exp=16", cyc); end
        tick();
        checks++;
        if ({ack_error, busy} !== 2'b00) begin
            failures++; $display("FAIL ack_pulse ack_error,busy=%b exp=00", {ack_error, busy});
        end
    endtask

    initial begin
        test_reset();
        test_empty_board();
        test_win_beats_block();
        test_block_and_x_steal();
        test_full_board();
        test_abort();
        test_ack_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
